// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command parser: state encodings, default header, frame lengths.
// Frame length depends on UART_CMD_CHECKSUM_EN (checksum byte present when defined).
package uart_cmd_pkg;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   localparam int FRAME_LEN_CHK   = 5;
   localparam int FRAME_LEN_NOCHK = 4;
`ifdef UART_CMD_CHECKSUM_EN
   localparam int FRAME_LEN = FRAME_LEN_CHK;
   localparam int OPC_W     = 8;
`else
   localparam int FRAME_LEN = FRAME_LEN_NOCHK;
   localparam int OPC_W     = 4;
`endif

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_GET_OPC = 3'd1;
   localparam state_t ST_GET_A   = 3'd2;
   localparam state_t ST_GET_B   = 3'd3;
   localparam state_t ST_GET_CHK = 3'd4;
   localparam state_t ST_HOLD    = 3'd5;

   function automatic logic [7:0] frame_chk(input logic [7:0] opc,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
      return opc ^ a ^ b;
   endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte timeout counter: clears on request, counts while enabled, saturates at TIMEOUT_CYCLES-1.
// expire is asserted while enabled and the count has reached its last value.
module uart_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses HEADER,OPC,A,B[,CHK] byte frames into an ALU command with valid/ready handoff.
// UART_CMD_CHECKSUM_EN defined adds the CHK byte and checksum error reporting.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] HEADER         = DEFAULT_HEADER,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [3:0] alu_op,
   output logic [7:0] op_a,
   output logic [7:0] op_b,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic       err_checksum,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       busy
);

   state_t           state_q, state_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   logic [7:0]       a_q, a_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [7:0]       op_a_q, op_a_d;
   logic [7:0]       op_b_q, op_b_d;
   logic             err_timeout_q, err_timeout_d;
   logic             err_overrun_q, err_overrun_d;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]       b_q, b_d;
   logic             err_checksum_q, err_checksum_d;
`endif
   logic             accept;
   logic             in_frame;
   logic             expire;

   assign in_frame = (state_q == ST_GET_OPC) || (state_q == ST_GET_A) ||
                     (state_q == ST_GET_B)   || (state_q == ST_GET_CHK);

   uart_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (accept),
      .enable(in_frame),
      .expire(expire)
   );

   always_comb begin
      state_d       = state_q;
      opc_d         = opc_q;
      a_d           = a_q;
      alu_op_d      = alu_op_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;
      accept        = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      b_d            = b_q;
      err_checksum_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) begin
               accept  = 1'b1;
               state_d = ST_GET_OPC;
            end
         end
         ST_GET_OPC: begin
            if (rx_valid) begin
               accept  = 1'b1;
               opc_d   = rx_data[OPC_W-1:0];
               state_d = ST_GET_A;
            end else if (expire) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_GET_A: begin
            if (rx_valid) begin
               accept  = 1'b1;
               a_d     = rx_data;
               state_d = ST_GET_B;
            end else if (expire) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_GET_B: begin
            if (rx_valid) begin
               accept = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
               b_d     = rx_data;
               state_d = ST_GET_CHK;
`else
               alu_op_d = opc_q[3:0];
               op_a_d   = a_q;
               op_b_d   = rx_data;
               state_d  = ST_HOLD;
`endif
            end else if (expire) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
`ifdef UART_CMD_CHECKSUM_EN
         ST_GET_CHK: begin
            if (rx_valid) begin
               accept = 1'b1;
               // A bad checksum leaves the previously presented command untouched.
               if (rx_data == frame_chk(opc_q, a_q, b_q)) begin
                  alu_op_d = opc_q[3:0];
                  op_a_d   = a_q;
                  op_b_d   = b_q;
                  state_d  = ST_HOLD;
               end else begin
                  err_checksum_d = 1'b1;
                  state_d        = ST_IDLE;
               end
            end else if (expire) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
`endif
         ST_HOLD: begin
            if (cmd_ready) begin
               state_d = ST_IDLE;
               if (rx_valid && (rx_data == HEADER)) begin
                  accept  = 1'b1;
                  state_d = ST_GET_OPC;
               end
            end else if (rx_valid) begin
               err_overrun_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         opc_q          <= '0;
         a_q            <= '0;
         alu_op_q       <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         err_timeout_q  <= 1'b0;
         err_overrun_q  <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
         b_q            <= '0;
         err_checksum_q <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         opc_q          <= opc_d;
         a_q            <= a_d;
         alu_op_q       <= alu_op_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         err_timeout_q  <= err_timeout_d;
         err_overrun_q  <= err_overrun_d;
`ifdef UART_CMD_CHECKSUM_EN
         b_q            <= b_d;
         err_checksum_q <= err_checksum_d;
`endif
      end
   end

   assign alu_op      = alu_op_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;
   assign cmd_valid   = (state_q == ST_HOLD);
   assign busy        = (state_q != ST_IDLE);
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
`ifdef UART_CMD_CHECKSUM_EN
   assign err_checksum = err_checksum_q;
`else
   assign err_checksum = 1'b0;
`endif

endmodule
